// File: rtl/spi_master_if.sv
// Host-side bus of spi_master: SPI pins, transaction request fields and the
// byte-buffer port, bundled with a master view (the controller) and a slave view.
interface spi_master_if #(
  parameter int COMMAND_SIZE = 6,
  parameter int AW           = 6
);
  logic                         sclk;
  logic                         cs_n;
  logic                         mosi;
  logic                         miso;
  logic [COMMAND_SIZE-1:0][7:0] cmd;
  logic                         op;
  logic [AW-1:0]                size;
  logic                         start;
  logic [AW-1:0]                address;
  logic [7:0]                   data_in;
  logic [7:0]                   data_out;
  logic                         wr;
  logic                         busy;
  logic                         done;

  modport master (
    output sclk, cs_n, mosi, address, data_out, wr, busy, done,
    input  miso, cmd, op, size, start, data_in
  );

  modport slave (
    input  sclk, cs_n, mosi, address, data_out, wr, busy, done,
    output miso, cmd, op, size, start, data_in
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: sends COMMAND_SIZE command bytes, one 0xFF gap byte, then
// writes size+1 buffer bytes to the responder or reads size+1 bytes into the buffer.
module spi_master #(
  parameter int COMMAND_SIZE         = 6,
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int CLK_DIV              = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);
  localparam int AW  = $clog2(MEMORY_SIZE_IN_BYTES);
  localparam int DW  = $clog2(CLK_DIV);
  localparam int CIW = $clog2(COMMAND_SIZE + 1);
  localparam int CMW = 8 * COMMAND_SIZE;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CIW-1:0] CMD_LAST = CIW'(COMMAND_SIZE - 1);

  typedef enum logic [2:0] {IDLE, COMMAND, GAP, WRITE, READ} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [2:0]     bit_q, bit_d;
  logic [AW-1:0]  byte_q, byte_d;
  logic [CIW-1:0] cidx_q, cidx_d;
  logic [CMW-1:0] cmd_sr_q, cmd_sr_d;
  logic [6:0]     tx_q, tx_d;
  logic [6:0]     rx_q, rx_d;
  logic           op_q, op_d;
  logic [AW-1:0]  size_q, size_d;
  logic           adv_q, adv_d;
  logic           sclk_q, sclk_d;
  logic           cs_n_q, cs_n_d;
  logic           mosi_q, mosi_d;
  logic [AW-1:0]  address_q, address_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           wr_q, wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic tick, rise, fall, boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      cidx_q     <= '0;
      cmd_sr_q   <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      op_q       <= 1'b0;
      size_q     <= '0;
      adv_q      <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
      address_q  <= '0;
      data_out_q <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      cidx_q     <= cidx_d;
      cmd_sr_q   <= cmd_sr_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      op_q       <= op_d;
      size_q     <= size_d;
      adv_q      <= adv_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    cidx_d     = cidx_q;
    cmd_sr_d   = cmd_sr_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    op_d       = op_q;
    size_d     = size_q;
    adv_d      = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    wr_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    tick     = (div_q == DIV_LAST);
    rise     = tick && !sclk_q;
    fall     = tick && sclk_q;
    // bit_q wraps 0 -> 7 on the bit-0 rise, so a fall seeing 7 ends a byte
    boundary = fall && (bit_q == 3'd7);

    if (state_q == IDLE) begin
      // a start in the same cycle as done is dropped on purpose
      if (bus.start && !done_q) begin
        state_d   = COMMAND;
        cmd_sr_d  = bus.cmd >> 8;
        mosi_d    = bus.cmd[0][7];
        tx_d      = bus.cmd[0][6:0];
        op_d      = bus.op;
        size_d    = bus.size;
        cs_n_d    = 1'b0;
        busy_d    = 1'b1;
        div_d     = '0;
        bit_d     = 3'd7;
        byte_d    = '0;
        cidx_d    = '0;
        rx_d      = '0;
        address_d = '0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) sclk_d = !sclk_q;
      // the buffer address runs one byte ahead of the byte being shifted out
      if (adv_q) address_d = byte_q + 1'b1;

      if (rise) begin
        rx_d  = {rx_q[5:0], bus.miso};
        bit_d = bit_q - 1'b1;
        if (state_q == READ && bit_q == 3'd0) begin
          data_out_d = {rx_q, bus.miso};
          address_d  = byte_q;
          wr_d       = 1'b1;
        end
      end

      if (fall && !boundary) begin
        mosi_d = tx_q[6];
        tx_d   = {tx_q[5:0], 1'b1};
      end

      if (boundary) begin
        unique case (state_q)
          COMMAND: begin
            if (cidx_q == CMD_LAST) begin
              state_d   = GAP;
              mosi_d    = 1'b1;
              tx_d      = '1;
              address_d = '0;
            end else begin
              cidx_d   = cidx_q + 1'b1;
              mosi_d   = cmd_sr_q[7];
              tx_d     = cmd_sr_q[6:0];
              cmd_sr_d = cmd_sr_q >> 8;
            end
          end
          GAP: begin
            byte_d = '0;
            if (op_q) begin
              state_d = WRITE;
              mosi_d  = bus.data_in[7];
              tx_d    = bus.data_in[6:0];
              adv_d   = 1'b1;
            end else begin
              state_d = READ;
              mosi_d  = 1'b1;
              tx_d    = '1;
            end
          end
          default: begin
            if (byte_q == size_q) begin
              state_d = IDLE;
              sclk_d  = 1'b0;
              cs_n_d  = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              mosi_d  = 1'b1;
              tx_d    = '0;
              div_d   = '0;
            end else begin
              byte_d = byte_q + 1'b1;
              if (state_q == WRITE) begin
                mosi_d = bus.data_in[7];
                tx_d   = bus.data_in[6:0];
                adv_d  = 1'b1;
              end else begin
                mosi_d = 1'b1;
                tx_d   = '1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.address  = address_q;
  assign bus.data_out = data_out_q;
  assign bus.wr       = wr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a responder/buffer model predicts the mosi bit stream
// and the wr strobes of each transaction, and a per-cycle monitor compares.
module tb_spi_master;
  localparam int CS  = 6;
  localparam int MEM = 64;
  localparam int AW  = 6;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.COMMAND_SIZE(CS), .AW(AW)) bus  ();
  spi_master_if #(.COMMAND_SIZE(CS), .AW(AW)) bus2 ();
  spi_master_if #(.COMMAND_SIZE(CS), .AW(AW)) bus5 ();

  spi_master #(.COMMAND_SIZE(CS), .MEMORY_SIZE_IN_BYTES(MEM), .CLK_DIV(DIV))
    dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  spi_master #(.COMMAND_SIZE(CS), .MEMORY_SIZE_IN_BYTES(MEM), .CLK_DIV(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  spi_master #(.COMMAND_SIZE(CS), .MEMORY_SIZE_IN_BYTES(MEM), .CLK_DIV(5))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  logic [7:0] mem  [MEM];
  logic [7:0] rspv [CS+1+MEM];
  logic [7:0] cmdv [CS];
  assign bus.data_in  = mem[bus.address];
  assign bus2.data_in = 8'hA5;
  assign bus5.data_in = 8'hA5;
  assign bus2.miso    = 1'b0;
  assign bus5.miso    = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  bit            exp_mosi [$];
  bit            rsp_bits [$];
  logic [AW+7:0] exp_wr [$];
  logic [7:0]    got_bytes [$];
  logic [AW-1:0] wr_addr_log [$];
  logic [7:0]    wr_data_log [$];

  int rises, rises2, rises5, dones, dones2, dones5, nbits;
  int run, run2, run5;
  logic [7:0] shreg;
  logic p_s, p_c, p2s, p2c, p5s, p5c;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  task automatic half_chk(input string nm, input int div, input logic s, input logic ps,
                          input logic c, input logic pc, inout int r);
    if (!pc) begin
      if (s != ps) begin
        check(nm, r, div);
        r = 1;
      end else r++;
    end else if (!c) r = 1;
  endtask

  // per-cycle monitor
  initial begin
    logic [AW+7:0] e;
    bit eb;
    p_s = 0; p_c = 1; p2s = 0; p2c = 1; p5s = 0; p5c = 1;
    run = 0; run2 = 0; run5 = 0; shreg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_s = 0; p_c = 1; p2s = 0; p2c = 1; p5s = 0; p5c = 1;
      end else begin
        check("busy_vs_cs", bus.busy, !bus.cs_n);
        if (bus.cs_n) check("sclk_idle", bus.sclk, 1'b0);
        if (bus.sclk && !p_s && !bus.cs_n) begin
          rises++;
          shreg = {shreg[6:0], bus.mosi};
          nbits++;
          if (nbits % 8 == 0) got_bytes.push_back(shreg);
          if (exp_mosi.size() == 0) fail_evt("mosi_extra_bit");
          else begin
            eb = exp_mosi.pop_front();
            check("mosi_bit", bus.mosi, eb);
          end
        end
        if (bus.wr) begin
          wr_addr_log.push_back(bus.address);
          wr_data_log.push_back(bus.data_out);
          check("wr_with_done", bus.done, 1'b0);
          if (exp_wr.size() == 0) fail_evt("wr_unexpected");
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", bus.address, e[AW+7:8]);
            check("wr_data", bus.data_out, e[7:0]);
          end
        end
        if (bus.done) dones++;
        half_chk("half_period_div4", DIV, bus.sclk, p_s, bus.cs_n, p_c, run);
        p_s = bus.sclk; p_c = bus.cs_n;

        check("busy_vs_cs_div2", bus2.busy, !bus2.cs_n);
        if (bus2.cs_n) check("sclk_idle_div2", bus2.sclk, 1'b0);
        if (bus2.sclk && !p2s && !bus2.cs_n) rises2++;
        if (bus2.done) dones2++;
        half_chk("half_period_div2", 2, bus2.sclk, p2s, bus2.cs_n, p2c, run2);
        p2s = bus2.sclk; p2c = bus2.cs_n;

        check("busy_vs_cs_div5", bus5.busy, !bus5.cs_n);
        if (bus5.cs_n) check("sclk_idle_div5", bus5.sclk, 1'b0);
        if (bus5.sclk && !p5s && !bus5.cs_n) rises5++;
        if (bus5.done) dones5++;
        half_chk("half_period_div5", 5, bus5.sclk, p5s, bus5.cs_n, p5c, run5);
        p5s = bus5.sclk; p5c = bus5.cs_n;
      end
    end
  end

  // responder: presents the next miso bit after each sclk fall
  initial begin
    logic rs, rc;
    rs = 0; rc = 1;
    bus.miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rs = 0; rc = 1; bus.miso = 1'b0;
      end else begin
        if ((rc && !bus.cs_n) || (!bus.cs_n && rs && !bus.sclk))
          bus.miso = (rsp_bits.size() != 0) ? rsp_bits.pop_front() : 1'b0;
        rs = bus.sclk; rc = bus.cs_n;
      end
    end
  end

  task automatic start_txn(input logic o, input int sz);
    int nb;
    logic [7:0] b;
    nb = CS + 1 + sz + 1;
    exp_mosi.delete(); exp_wr.delete(); rsp_bits.delete(); got_bytes.delete();
    wr_addr_log.delete(); wr_data_log.delete();
    rises = 0; dones = 0; nbits = 0;
    for (int j = 0; j < nb; j++) begin
      if (j < CS) b = cmdv[j];
      else if (j == CS || !o) b = 8'hFF;
      else b = mem[j-CS-1];
      for (int i = 7; i >= 0; i--) exp_mosi.push_back(b[i]);
      for (int i = 7; i >= 0; i--) rsp_bits.push_back(rspv[j][i]);
      if (!o && j > CS) exp_wr.push_back({AW'(j-CS-1), rspv[j]});
    end
    for (int j = 0; j < CS; j++) bus.cmd[j] = cmdv[j];
    bus.op   = o;
    bus.size = AW'(sz);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic finish_txn(input int nb);
    bit ok;
    ok = 0;
    for (int i = 0; i < nb * 16 * DIV + 100; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1; break; end
    end
    if (!ok) fail_evt("done_timeout");
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("start_at_done_ignored", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    check("done_count", dones, 1);
    check("sclk_periods", rises, 8 * nb);
    check("mosi_pending", exp_mosi.size(), 0);
    check("wr_pending", exp_wr.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_sclk"}, bus.sclk, 1'b0);
    check({tag, "_cs_n"}, bus.cs_n, 1'b1);
    check({tag, "_mosi"}, bus.mosi, 1'b1);
    check({tag, "_address"}, bus.address, '0);
    check({tag, "_data_out"}, bus.data_out, 8'h00);
    check({tag, "_wr"}, bus.wr, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected end within budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] lit [8];
    bit ok;
    bus.start = 0; bus.op = 0; bus.size = '0; bus.cmd = '0;
    bus2.start = 0; bus2.op = 1; bus2.size = '0; bus2.cmd = '0;
    bus5.start = 0; bus5.op = 1; bus5.size = '0; bus5.cmd = '0;
    for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
    for (int j = 0; j < CS + 1 + MEM; j++) rspv[j] = 8'(j * 37 + 5);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // command-only write of one byte
    cmdv = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    mem[0] = 8'hA5;
    start_txn(1'b1, 0);
    finish_txn(CS + 2);
    lit = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hA5};
    for (int i = 0; i < 8; i++) check("cmd_only_byte", got_bytes[i], lit[i]);
    check("cmd_only_periods", rises, 64);
    check("cmd_only_no_wr", wr_addr_log.size(), 0);

    // same transaction on the CLK_DIV = 2 and 5 instances
    for (int j = 0; j < CS; j++) begin bus2.cmd[j] = cmdv[j]; bus5.cmd[j] = cmdv[j]; end
    rises2 = 0; rises5 = 0; dones2 = 0; dones5 = 0;
    @(posedge clk); #1 bus2.start = 1'b1; bus5.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0; bus5.start = 1'b0;
    check("busy_div2", bus2.busy, 1'b1);
    check("busy_div5", bus5.busy, 1'b1);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dones2 >= 1 && dones5 >= 1) begin ok = 1; break; end
    end
    if (!ok) fail_evt("div_done_timeout");
    repeat (2) @(negedge clk);
    check("periods_div2", rises2, 64);
    check("periods_div5", rises5, 64);
    check("dones_div2", dones2, 1);
    check("dones_div5", dones5, 1);

    // read 4 bytes, with a start pulse and input changes mid-transaction
    cmdv = '{8'h03, 8'h00, 8'h10, 8'h20, 8'h7E, 8'h81};
    rspv[7] = 8'h11; rspv[8] = 8'h22; rspv[9] = 8'h33; rspv[10] = 8'h44;
    start_txn(1'b0, 3);
    repeat (150) @(posedge clk);
    #1;
    for (int j = 0; j < CS; j++) bus.cmd[j] = 8'hEE;
    bus.op = 1'b1; bus.size = AW'(9); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    finish_txn(CS + 5);
    check("read_wr_count", wr_addr_log.size(), 4);
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) begin
      check("read_addr", wr_addr_log[k], AW'(k));
      check("read_data", wr_data_log[k], lit[k]);
      check("read_mosi_ff", got_bytes[7 + k], 8'hFF);
    end

    // full-buffer write
    for (int i = 0; i < MEM; i++) mem[i] = 8'(i);
    cmdv = '{8'h58, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF};
    start_txn(1'b1, MEM - 1);
    finish_txn(CS + 1 + MEM);
    check("write_byte_count", got_bytes.size(), 71);
    check("write_byte_10", got_bytes[23], 8'h10);
    check("write_byte_3f", got_bytes[70], 8'h3F);
    check("write_no_wr", wr_addr_log.size(), 0);

    // reset during READ byte 1
    cmdv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rspv[7] = 8'hA1; rspv[8] = 8'hB2; rspv[9] = 8'hC3; rspv[10] = 8'hD4;
    start_txn(1'b0, 3);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_addr_log.size() == 1) begin ok = 1; break; end
    end
    if (!ok) fail_evt("abort_wait_timeout");
    check("abort_byte0_data", bus.data_out, 8'hA1);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("abort");
    repeat (3) @(negedge clk);
    check("abort_no_done", dones, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // fresh transaction after the abort
    rspv[7] = 8'h3C; rspv[8] = 8'hC3;
    start_txn(1'b0, 1);
    finish_txn(CS + 3);
    check("post_abort_wr0", wr_data_log[0], 8'h3C);
    check("post_abort_wr1", wr_data_log[1], 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameters: COMMAND_SIZE, default 6, command bytes per transaction; MEMORY_SIZE_IN_BYTES, default 64, buffer depth; CLK_DIV, default 4, clk cycles per sclk half-period, legal range >= 2.
REQ-002 Let AW = $clog2(MEMORY_SIZE_IN_BYTES).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sclk  out  1  SPI clock, mode 0, idle low.
REQ-006 cs_n  out  1  chip select, active low.
REQ-007 mosi  out  1  serial data to responder, MSB first.
REQ-008 miso  in  1  serial data from responder, MSB first.
REQ-009 cmd  in  8 x COMMAND_SIZE  command bytes, cmd[0] sent first; captured at start.
REQ-010 op  in  1  0 = read from responder, 1 = write to responder; captured at start.
REQ-011 size  in  AW  last byte index; transfers size+1 bytes; captured at start.
REQ-012 start  in  1  one-cycle request; honoured only when busy = 0.
REQ-013 address  out  AW  buffer index for the current data byte.
REQ-014 data_in  in  8  buffer byte at address, used in write phase.
REQ-015 data_out  out  8  received byte, valid while wr = 1.
REQ-016 wr  out  1  one-cycle strobe: store data_out at address.
REQ-017 busy  out  1  high from start acceptance until done.
REQ-018 done  out  1  one-cycle pulse at transaction end.

Function
REQ-019 States: IDLE, COMMAND, GAP, WRITE, READ; all outputs registered.
REQ-020 Divider counts 0..CLK_DIV-1 while not IDLE; terminal count is a tick; each tick toggles sclk; low->high tick = rise, high->low = fall.
REQ-021 IDLE + start: capture cmd/op/size, cs_n <= 0, busy <= 1, mosi <= cmd[0][7], divider and counters cleared, enter COMMAND; first rise CLK_DIV cycles later.
REQ-022 miso sampled into a receive shift register at each rise; mosi updates only at falls (except REQ-021).
REQ-023 Bit counter 7..0 decrements on each rise; byte boundary = fall following rise with bit 0.
REQ-024 COMMAND: shift COMMAND_SIZE bytes in order; at last boundary enter GAP.
REQ-025 GAP: one byte of mosi = 1; received bits discarded; at boundary enter WRITE if op = 1 else READ; byte counter <= 0.
REQ-026 WRITE: transmit register loaded from data_in on the boundary cycle entering byte k; address <= k+1 on the cycle after the load (address = 0 on GAP entry); data_in must be stable by the load cycle.
REQ-027 READ: mosi held 1; at the rise of bit 0 of byte k, data_out <= received byte, address <= k, wr <= 1 for exactly one clk cycle.
REQ-028 After byte index size completes (its boundary fall): sclk low, cs_n <= 1, busy <= 0, done <= 1 for one cycle, enter IDLE.
REQ-029 Total sclk periods per transaction = 8 x (COMMAND_SIZE + 1 + size + 1).
REQ-030 size = 0 transfers exactly one data byte; size = MEMORY_SIZE_IN_BYTES-1 transfers full buffer; byte counter width AW with no wrap before terminating.
REQ-031 start while busy = 1 ignored; start coincident with done ignored (new start accepted on the next cycle or later).
REQ-032 cmd, op, size changes after capture have no effect on the transaction in flight.
REQ-033 wr never asserted in COMMAND, GAP, or WRITE; done never coincides with wr.

Reset
REQ-034 rst_n low forces immediately: state IDLE, sclk 0, cs_n 1, mosi 1, address 0, data_out 0, wr 0, busy 0, done 0, all counters and shift registers 0.
REQ-035 Reset mid-transaction aborts without done; next start after release begins a fresh transaction.

Verification
REQ-036 Command only: cmd = {40,00,00,00,00,95}, op = 1, size = 0, data_in = A5 -> mosi bytes 40 00 00 00 00 95 FF A5, 64 sclk periods, one done pulse.
REQ-037 Read: op = 0, size = 3, responder returns 11 22 33 44 -> wr pulses at address 0..3 with data_out 11, 22, 33, 44, mosi = 1 throughout data phase.
REQ-038 Write: op = 1, size = 63, buffer[i] = i -> mosi data bytes 00..3F, address increments 0..63, no wr.
REQ-039 Timing: CLK_DIV = 2 and 5 -> sclk half-period 2 and 5 clk cycles, cs_n low for entire transaction, sclk low when cs_n rises.
REQ-040 start pulsed mid-transaction -> ignored; rst_n asserted during READ byte 1 -> all outputs at reset values immediately, no done, subsequent transaction correct.
